parallel2serial_stream: RTL and testbench

- Multi-lane, multi-word parallel-to-serial converter with a runtime-programmable serial clock divider.
- Streams a frame of (len+1) words per start command.
- Takes words through a valid/ready input with a one-word holding buffer, so consecutive words shift out with no gaps.
- Sits between a CPU/bus-side producer and off-chip shift-register chains (display, LED, DAC) that share s_clk/s_clr across LANES data lines.

---
 rtl/p2s_pkg.sv | 16 +
 rtl/sclk_gen.sv | 40 ++++
 rtl/parallel2serial_stream.sv | 189 ++++++++++++++++++
 tb/tb_parallel2serial_stream.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared types for the parallel-to-serial stream converter.
// State encoding and counter sizing helper.
package p2s_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_DONE
   } state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sclk_gen.sv
// Serial clock divider: s_clk half-period is div_q+1 clk cycles.
// rise/fall strobe on the clk cycle before s_clk changes.
module sclk_gen #(
   parameter int DIV_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                hold,
   input  logic [DIV_BITS-1:0] div_q,
   output logic                s_clk,
   output logic                rise,
   output logic                fall
);

   logic [DIV_BITS-1:0] half_cnt;
   logic                tc;

   assign tc   = enable & ~hold & (half_cnt == div_q);
   assign rise = tc & ~s_clk;
   assign fall = tc & s_clk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         half_cnt <= '0;
         s_clk    <= 1'b0;
      end else if (!enable) begin
         half_cnt <= '0;
         s_clk    <= 1'b0;
      end else if (hold) begin
         half_cnt <= '0;
      end else if (tc) begin
         half_cnt <= '0;
         s_clk    <= ~s_clk;
      end else begin
         half_cnt <= half_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/parallel2serial_stream.sv
// Multi-lane parallel-to-serial streamer with a one-word holding buffer.
// Frames of len+1 words, programmable s_clk divider, clear preamble.
module parallel2serial_stream
   import p2s_pkg::*;
#(
   parameter int DATA_BITS   = 32,
   parameter int LANES       = 1,
   parameter int CODE_ENDIAN = 0,
   parameter int DIV_BITS    = 8,
   parameter int LEN_BITS    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DIV_BITS-1:0]        div,
   input  logic [LEN_BITS-1:0]        len,
   input  logic                       start,
   input  logic [LANES*DATA_BITS-1:0] in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       busy,
   output logic                       finish,
   output logic                       underrun,
   output logic                       s_clk,
   output logic                       s_clr,
   output logic [LANES-1:0]           s_dat
);

   localparam int W  = LANES * DATA_BITS;
   localparam int CW = cnt_width(DATA_BITS + 1);

   state_t              state;
   logic [DIV_BITS-1:0] div_q;
   logic [LEN_BITS-1:0] len_q;
   logic [LEN_BITS-1:0] word_cnt;
   logic [DIV_BITS:0]   clr_cnt;
   logic [CW-1:0]       bit_cnt;
   logic [W-1:0]        hold_q;
   logic [W-1:0]        sr;
   logic                hold_full;
   logic                active;
   logic                stall;
   logic                sclk_en;
   logic                rise;
   logic                fall;
   logic                accept;
   logic                word_end;
   logic                last_word;

   assign in_ready  = busy & ~hold_full;
   assign accept    = in_valid & in_ready;
   assign sclk_en   = (state == S_SHIFT) & active;
   assign word_end  = fall & (bit_cnt == CW'(DATA_BITS));
   assign last_word = (word_cnt == len_q);

   sclk_gen #(
      .DIV_BITS (DIV_BITS)
   ) u_sclk (
      .clk    (clk),
      .rst    (rst),
      .enable (sclk_en),
      .hold   (stall),
      .div_q  (div_q),
      .s_clk  (s_clk),
      .rise   (rise),
      .fall   (fall)
   );

   function automatic logic [W-1:0] shift_lanes(input logic [W-1:0] v);
      logic [W-1:0]         r;
      logic [DATA_BITS-1:0] l;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         l = v[k*DATA_BITS +: DATA_BITS];
         r[k*DATA_BITS +: DATA_BITS] =
            (CODE_ENDIAN != 0) ? (l << 1) : (l >> 1);
      end
      return r;
   endfunction

   always_comb begin
      s_dat = '0;
      for (int k = 0; k < LANES; k++) begin
         s_dat[k] = (CODE_ENDIAN != 0)
                  ? sr[k*DATA_BITS + DATA_BITS - 1]
                  : sr[k*DATA_BITS];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         div_q     <= '0;
         len_q     <= '0;
         word_cnt  <= '0;
         clr_cnt   <= '0;
         bit_cnt   <= '0;
         hold_q    <= '0;
         sr        <= '0;
         hold_full <= 1'b0;
         active    <= 1'b0;
         stall     <= 1'b0;
         busy      <= 1'b0;
         finish    <= 1'b0;
         underrun  <= 1'b0;
         s_clr     <= 1'b0;
      end else begin
         finish <= 1'b0;
         if (accept) begin
            hold_q    <= in_data;
            hold_full <= 1'b1;
         end
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_CLEAR;
                  div_q    <= div;
                  len_q    <= len;
                  word_cnt <= '0;
                  clr_cnt  <= '0;
                  busy     <= 1'b1;
                  underrun <= 1'b0;
                  s_clr    <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (clr_cnt == {div_q, 1'b1}) begin
                  state <= S_SHIFT;
                  s_clr <= 1'b0;
                  if (hold_full) begin
                     sr        <= hold_q;
                     hold_full <= 1'b0;
                     active    <= 1'b1;
                     bit_cnt   <= '0;
                  end
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            S_SHIFT: begin
               if (!active) begin
                  // first word not yet offered: wait, not an underrun
                  if (hold_full) begin
                     sr        <= hold_q;
                     hold_full <= 1'b0;
                     active    <= 1'b1;
                     bit_cnt   <= '0;
                  end
               end else if (stall) begin
                  if (hold_full) begin
                     sr        <= hold_q;
                     hold_full <= 1'b0;
                     stall     <= 1'b0;
                     bit_cnt   <= '0;
                     word_cnt  <= word_cnt + 1'b1;
                  end
               end else begin
                  if (rise) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
                  if (word_end) begin
                     if (last_word) begin
                        state     <= S_DONE;
                        active    <= 1'b0;
                        sr        <= '0;
                        busy      <= 1'b0;
                        finish    <= 1'b1;
                        hold_full <= 1'b0;
                     end else if (hold_full) begin
                        sr        <= hold_q;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        word_cnt  <= word_cnt + 1'b1;
                     end else begin
                        stall    <= 1'b1;
                        underrun <= 1'b1;
                     end
                  end else if (fall) begin
                     sr <= shift_lanes(sr);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parallel2serial_stream.sv
// Directed self-checking bench for parallel2serial_stream.
// Two instances: 2-lane LSB-first and 1-lane MSB-first.
module tb_parallel2serial_stream;

   logic        clk;
   logic        rst;
   logic [7:0]  div;
   logic [7:0]  len;
   logic        start;
   logic        start_b;
   logic [15:0] in_data;
   logic        in_valid;
   logic [7:0]  data_b;
   logic        valid_b;

   logic        in_ready, busy, finish, underrun, s_clk, s_clr;
   logic [1:0]  s_dat;
   logic        in_ready_b, busy_b, finish_b, underrun_b, s_clk_b, s_clr_b;
   logic [0:0]  s_dat_b;

   int checks;
   int failures;
   int cyc;
   int t0;
   logic stat_rst;

   logic [1:0] bits[$];
   int clr_cyc, fin_cnt, fin_cyc, gmin, gmax, last_rise, lowrun, maxlow;
   logic have_last, prev;

   logic bits_b[$];
   int finb_cnt, finb_cyc, gbmin, gbmax, lastb;
   logic haveb, prevb;

   parallel2serial_stream #(
      .DATA_BITS(8), .LANES(2), .CODE_ENDIAN(0),
      .DIV_BITS(8), .LEN_BITS(8)
   ) u_le (
      .clk(clk), .rst(rst), .div(div), .len(len),
      .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .busy(busy), .finish(finish),
      .underrun(underrun), .s_clk(s_clk), .s_clr(s_clr),
      .s_dat(s_dat)
   );

   parallel2serial_stream #(
      .DATA_BITS(8), .LANES(1), .CODE_ENDIAN(1),
      .DIV_BITS(8), .LEN_BITS(8)
   ) u_be (
      .clk(clk), .rst(rst), .div(div), .len(len),
      .start(start_b), .in_data(data_b), .in_valid(valid_b),
      .in_ready(in_ready_b), .busy(busy_b), .finish(finish_b),
      .underrun(underrun_b), .s_clk(s_clk_b), .s_clr(s_clr_b),
      .s_dat(s_dat_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (stat_rst) begin
         bits.delete();
         clr_cyc <= 0; fin_cnt <= 0; fin_cyc <= 0;
         gmin <= 1000000; gmax <= 0; have_last <= 1'b0;
         lowrun <= 0; maxlow <= 0; prev <= 1'b0;
      end else begin
         prev <= s_clk;
         if (s_clk && !prev) begin
            bits.push_back(s_dat);
            if (have_last) begin
               if (cyc - last_rise < gmin) gmin <= cyc - last_rise;
               if (cyc - last_rise > gmax) gmax <= cyc - last_rise;
            end
            last_rise <= cyc;
            have_last <= 1'b1;
         end
         if (busy && !s_clk) lowrun <= lowrun + 1;
         else begin
            if (lowrun > maxlow) maxlow <= lowrun;
            lowrun <= 0;
         end
         if (s_clr) clr_cyc <= clr_cyc + 1;
         if (finish) begin
            fin_cnt <= fin_cnt + 1;
            if (fin_cnt == 0) fin_cyc <= cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (stat_rst) begin
         bits_b.delete();
         finb_cnt <= 0; finb_cyc <= 0;
         gbmin <= 1000000; gbmax <= 0; haveb <= 1'b0; prevb <= 1'b0;
      end else begin
         prevb <= s_clk_b;
         if (s_clk_b && !prevb) begin
            bits_b.push_back(s_dat_b[0]);
            if (haveb) begin
               if (cyc - lastb < gbmin) gbmin <= cyc - lastb;
               if (cyc - lastb > gbmax) gbmax <= cyc - lastb;
            end
            lastb <= cyc;
            haveb <= 1'b1;
         end
         if (finish_b) begin
            finb_cnt <= finb_cnt + 1;
            if (finb_cnt == 0) finb_cyc <= cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack_le(input int lane);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < bits.size() && i < 32; i++) v[i] = bits[i][lane];
      return v;
   endfunction

   function automatic logic [31:0] pack_be();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < bits_b.size(); i++) v = {v[30:0], bits_b[i]};
      return v;
   endfunction

   task automatic start_frame(input bit b);
      @(negedge clk);
      #1 stat_rst = 1'b1;
      @(negedge clk);
      #1 stat_rst = 1'b0;
      if (b) start_b = 1'b1;
      else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_b = 1'b0;
      t0 = cyc;
   endtask

   task automatic push(input bit b, input logic [15:0] d);
      bit ok;
      ok = 1'b0;
      if (b) begin data_b = d[7:0]; valid_b = 1'b1; end
      else begin in_data = d; in_valid = 1'b1; end
      for (int i = 0; i < 2000; i++) begin
         if ((b ? in_ready_b : in_ready) === 1'b1) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      valid_b = 1'b0;
      chk("push_timeout", 32'(ok), 1);
   endtask

   task automatic wait_fin(input bit b, input int maxc);
      bit got;
      got = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if ((b ? finish_b : finish) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk("fin_timeout", 32'(got), 1);
   endtask

   initial begin
      bit got;
      checks = 0; failures = 0;
      rst = 1'b0; start = 1'b0; start_b = 1'b0;
      in_data = '0; in_valid = 1'b0; data_b = '0; valid_b = 1'b0;
      div = 8'd4; len = 8'd0; stat_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outs",
          {busy, finish, underrun, s_clk, s_clr, s_dat, in_ready}, 0);
      chk("reset_outs_b",
          {busy_b, finish_b, underrun_b, s_clk_b, s_clr_b, s_dat_b}, 0);
      rst = 1'b1;
      stat_rst = 1'b0;

      // single word 0xA5, div=4
      in_data = 16'h00A5; in_valid = 1'b1;
      start_frame(0);
      push(0, 16'h00A5);
      wait_fin(0, 400);
      chk("t1_busy_at_fin", 32'(busy), 0);
      @(negedge clk);
      chk("t1_fin_pulse", 32'(finish), 0);
      chk("t1_latency", fin_cyc - t0, 90);
      chk("t1_clr_cycles", clr_cyc, 10);
      chk("t1_nbits", bits.size(), 8);
      chk("t1_data", pack_le(0), 32'hA5);
      chk("t1_gap_min", gmin, 10);
      chk("t1_gap_max", gmax, 10);
      chk("t1_underrun", 32'(underrun), 0);
      chk("t1_fin_count", fin_cnt, 1);

      // three 2-lane words back to back
      div = 8'd1; len = 8'd2;
      start_frame(0);
      push(0, 16'h0FF0);
      push(0, 16'h33CC);
      push(0, 16'h55AA);
      wait_fin(0, 400);
      @(negedge clk);
      chk("t2_latency", fin_cyc - t0, 100);
      chk("t2_nbits", bits.size(), 24);
      chk("t2_lane0", pack_le(0), 32'hAACCF0);
      chk("t2_lane1", pack_le(1), 32'h55330F);
      chk("t2_gap_min", gmin, 4);
      chk("t2_gap_max", gmax, 4);
      chk("t2_underrun", 32'(underrun), 0);

      // second word late -> stall
      div = 8'd1; len = 8'd1;
      start_frame(0);
      push(0, 16'h005A);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (underrun === 1'b1) begin got = 1'b1; break; end
      end
      chk("t3_underrun_rise", 32'(got), 1);
      chk("t3_s_clk_low", 32'(s_clk), 0);
      repeat (30) @(negedge clk);
      push(0, 16'h00C3);
      wait_fin(0, 400);
      @(negedge clk);
      chk("t3_nbits", bits.size(), 16);
      chk("t3_data", pack_le(0), 32'hC35A);
      chk("t3_low_run", maxlow, 34);
      chk("t3_underrun_sticky", 32'(underrun), 1);

      // MSB first, div=0
      div = 8'd0; len = 8'd0;
      data_b = 8'h80; valid_b = 1'b1;
      start_frame(1);
      push(1, 16'h0080);
      wait_fin(1, 100);
      chk("t4_busy_at_fin", 32'(busy_b), 0);
      @(negedge clk);
      chk("t4_latency", finb_cyc - t0, 18);
      chk("t4_nbits", bits_b.size(), 8);
      chk("t4_data", pack_be(), 32'h80);
      chk("t4_gap_min", gbmin, 2);
      chk("t4_gap_max", gbmax, 2);
      chk("t4_underrun", 32'(underrun_b), 0);
      chk("t4_fin_count", finb_cnt, 1);

      // stray start and div/len change mid-frame
      div = 8'd1; len = 8'd1;
      start_frame(0);
      chk("t6_underrun_clr", 32'(underrun), 0);
      push(0, 16'h0012);
      push(0, 16'h0034);
      start = 1'b1; div = 8'd7; len = 8'd5;
      @(negedge clk);
      start = 1'b0;
      chk("t6_busy_mid", 32'(busy), 1);
      wait_fin(0, 500);
      @(negedge clk);
      chk("t6_latency", fin_cyc - t0, 68);
      chk("t6_nbits", bits.size(), 16);
      chk("t6_data", pack_le(0), 32'h3412);
      chk("t6_gap_min", gmin, 4);
      chk("t6_gap_max", gmax, 4);
      repeat (40) @(negedge clk);
      chk("t6_fin_count", fin_cnt, 1);
      chk("t6_idle", 32'(busy), 0);

      // asynchronous reset mid-shift, then a clean frame
      div = 8'd4; len = 8'd0;
      start_frame(0);
      push(0, 16'h0011);
      repeat (30) @(negedge clk);
      chk("t5_busy_pre", 32'(busy), 1);
      #2 rst = 1'b0;
      #1;
      chk("t5_async_outs",
          {busy, finish, underrun, s_clk, s_clr, s_dat, in_ready}, 0);
      @(negedge clk);
      rst = 1'b1;
      div = 8'd2; len = 8'd0;
      start_frame(0);
      push(0, 16'h003C);
      wait_fin(0, 200);
      @(negedge clk);
      chk("t5_latency", fin_cyc - t0, 54);
      chk("t5_nbits", bits.size(), 8);
      chk("t5_data", pack_le(0), 32'h3C);
      chk("t5_underrun", 32'(underrun), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
